// File: rtl/port_wr_frontend.sv
// rtl/port_wr_frontend.sv - per-port ingress header parse, matcher handshake and payload buffer
module port_wr_frontend #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_vld_i,
  input  logic                  wr_sop_i,
  input  logic                  wr_eop_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic [3:0]            new_dest_port_o,
  output logic [8:0]            new_length_o,
  output logic                  match_enable_o,
  input  logic                  match_suc_i,
  input  logic [4:0]            matching_best_sram_i,
  output logic                  xfer_vld_o,
  output logic [DATA_WIDTH-1:0] xfer_data_o,
  output logic                  xfer_sop_o,
  output logic                  xfer_eop_o,
  output logic [4:0]            xfer_sram_o,
  output logic [2:0]            xfer_prior_o,
  input  logic                  xfer_ready_i,
  output logic                  err_len_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, MATCH, STREAM} state_e;

  state_e                state_q;
  logic [DATA_WIDTH:0]   mem_q [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           fifo_cnt_q;
  logic [8:0]            rx_cnt_q, tx_cnt_q;
  logic                  rx_done_q;

  logic                  accept, push, pop, push_last, push_err;
  logic [8:0]            rx_idx_d, hdr_len;
  logic [DATA_WIDTH:0]   head;

  assign hdr_len    = wr_data_i[15:7];
  assign wr_ready_o = (state_q == IDLE) || (!rx_done_q && (fifo_cnt_q < DEPTH_C));
  assign accept     = wr_vld_i && wr_ready_o;
  assign push       = accept && (state_q != IDLE);
  assign rx_idx_d   = rx_cnt_q + 9'd1;

  // Each FIFO entry carries its own last-word tag; the stored tag, not wr_eop, ends the packet.
  assign push_last  = wr_eop_i || (rx_idx_d == new_length_o);
  assign push_err   = (wr_eop_i != (rx_idx_d == new_length_o)) || wr_sop_i;

  assign head        = mem_q[rd_ptr_q];
  assign xfer_vld_o  = (state_q == STREAM) && (fifo_cnt_q != '0);
  assign xfer_data_o = head[DATA_WIDTH-1:0];
  assign xfer_eop_o  = xfer_vld_o && head[DATA_WIDTH];
  assign xfer_sop_o  = xfer_vld_o && (tx_cnt_q == 9'd0);
  assign pop         = xfer_vld_o && xfer_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, wr_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
      rx_cnt_q        <= '0;
      tx_cnt_q        <= '0;
      rx_done_q       <= 1'b0;
      new_dest_port_o <= '0;
      new_length_o    <= '0;
      match_enable_o  <= 1'b0;
      xfer_sram_o     <= '0;
      xfer_prior_o    <= '0;
      err_len_o       <= 1'b0;
    end else begin
      err_len_o <= 1'b0;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        rx_cnt_q  <= rx_idx_d;
        err_len_o <= push_err;
        if (push_last) rx_done_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        tx_cnt_q <= tx_cnt_q + 9'd1;
      end
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (wr_vld_i && wr_sop_i) begin
            if (hdr_len == 9'd0) begin
              err_len_o <= 1'b1;
            end else begin
              new_dest_port_o <= wr_data_i[3:0];
              xfer_prior_o    <= wr_data_i[6:4];
              new_length_o    <= hdr_len;
              rx_cnt_q        <= '0;
              tx_cnt_q        <= '0;
              rx_done_q       <= 1'b0;
              match_enable_o  <= 1'b1;
              state_q         <= MATCH;
            end
          end
        end
        MATCH: begin
          // Dropping enable on success lets the matcher go idle without retriggering.
          if (match_suc_i) begin
            xfer_sram_o    <= matching_best_sram_i;
            match_enable_o <= 1'b0;
            state_q        <= STREAM;
          end
        end
        STREAM: begin
          if (pop && xfer_eop_o) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_wr_frontend.sv
// tb/tb_port_wr_frontend.sv - scoreboard bench with randomized packets and a behavioural matcher
module tb_port_wr_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_vld = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic [3:0]  new_dest_port;
  logic [8:0]  new_length;
  logic        match_enable;
  logic        match_suc = 1'b0;
  logic [4:0]  best_sram = '0;
  logic        xfer_vld, xfer_sop, xfer_eop, err_len;
  logic [15:0] xfer_data;
  logic [4:0]  xfer_sram;
  logic [2:0]  xfer_prior;
  logic        xfer_ready = 1'b1;

  port_wr_frontend #(.DATA_WIDTH(16), .BUF_DEPTH(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_vld_i(wr_vld), .wr_sop_i(wr_sop), .wr_eop_i(wr_eop), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready),
    .new_dest_port_o(new_dest_port), .new_length_o(new_length),
    .match_enable_o(match_enable), .match_suc_i(match_suc),
    .matching_best_sram_i(best_sram),
    .xfer_vld_o(xfer_vld), .xfer_data_o(xfer_data), .xfer_sop_o(xfer_sop),
    .xfer_eop_o(xfer_eop), .xfer_sram_o(xfer_sram), .xfer_prior_o(xfer_prior),
    .xfer_ready_i(xfer_ready), .err_len_o(err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    logic [4:0]  sram;
    logic [2:0]  prior;
  } exp_t;

  typedef struct {
    int         delay;
    logic [4:0] sram;
    logic [3:0] dest;
    logic [8:0] len;
  } mt_t;

  exp_t exp_q[$];
  mt_t  mq[$];
  int   n_cmp = 0, n_bad = 0;
  int   err_seen = 0, exp_err = 0;
  int   pay_acc = 0, suc_snap = 0;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural matcher: answers each enable window after the delay queued for that packet.
  int  mcnt = 0;
  mt_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = 0; match_suc = 1'b0; best_sram = '0;
    end else if (match_enable) begin
      mcnt++;
      if (mcnt == 1) begin
        if (mq.size() == 0) chk("matcher_request_unexpected", 32'd1, 32'd0);
        else begin
          cur = mq.pop_front();
          chk("new_dest_port", 32'(new_dest_port), 32'(cur.dest));
          chk("new_length", 32'(new_length), 32'(cur.len));
        end
      end
      match_suc = (mcnt == cur.delay + 1);
      best_sram = match_suc ? cur.sram : 5'd0;
      if (match_suc) suc_snap = pay_acc;
    end else begin
      if (mcnt != 0) chk("match_enable_cycles", 32'(mcnt), 32'(cur.delay + 1));
      mcnt = 0; match_suc = 1'b0; best_sram = '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len) err_seen++;
      if (xfer_vld && xfer_ready) begin
        if (exp_q.size() == 0) chk("egress_word_unexpected", 32'(xfer_data), 32'hffff_ffff);
        else chk("egress_word", 32'({xfer_data, xfer_sop, xfer_eop, xfer_sram, xfer_prior}),
                 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) xfer_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_word(input logic [15:0] d, input logic sop, input logic eop, input bit payload);
    int t = 0;
    @(negedge clk);
    wr_vld = 1'b1; wr_sop = sop; wr_eop = eop; wr_data = d;
    while (!wr_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("wr_ready_wait", 32'(t < 4000), 32'd1);
    @(posedge clk);
    if (payload) pay_acc++;
    #1 wr_vld = 1'b0;
  endtask

  // Expected egress: words 1..last where last is the first eop or the header length, whichever is earlier.
  task automatic send_pkt(input logic [3:0] dest, input logic [2:0] prior, input int len,
                          input int nwords, input int eop_at, input int delay,
                          input logic [4:0] sram, input int sop_at);
    logic [15:0] pay[];
    int last;
    exp_t e;
    pay = new[nwords + 1];
    for (int k = 1; k <= nwords; k++) pay[k] = 16'($urandom);
    last = (eop_at != 0 && eop_at <= len) ? eop_at : len;
    if (len == 0) exp_err++;
    else begin
      if (eop_at != len) exp_err++;
      if (sop_at != 0 && sop_at <= last) exp_err++;
      mq.push_back('{delay, sram, dest, 9'(len)});
    end
    pay_acc = 0;
    send_word({9'(len), prior, dest}, 1'b1, 1'b0, 1'b0);
    if (len != 0) begin
      chk("header_after_prev_eop", 32'(exp_q.size()), 32'd0);
      for (int k = 1; k <= last; k++) begin
        e.d = pay[k]; e.sop = (k == 1); e.eop = (k == last); e.sram = sram; e.prior = prior;
        exp_q.push_back(e);
      end
    end
    for (int k = 1; k <= nwords; k++) send_word(pay[k], k == sop_at, k == eop_at, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || mq.size() != 0 || match_enable) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(t < 6000), 32'd1);
    repeat (3) @(negedge clk);
    chk("err_len_count", 32'(err_seen), 32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_match_enable"}, 32'(match_enable), 32'd0);
    chk({tag, "_xfer_vld"}, 32'(xfer_vld), 32'd0);
    chk({tag, "_err_len"}, 32'(err_len), 32'd0);
    chk({tag, "_new_fields"}, 32'({new_dest_port, new_length}), 32'd0);
    chk({tag, "_xfer_sram_prior"}, 32'({xfer_sram, xfer_prior}), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end

  initial begin
    int len, mode, n, e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    send_pkt(4'd5, 3'd2, 4, 4, 4, 10, 5'd17, 0);
    drain();

    send_pkt(4'd9, 3'd6, 100, 100, 100, 70, 5'(urandom_sram()), 0);
    drain();
    chk("buffered_before_match", 32'(suc_snap), 32'd64);

    send_pkt(4'd3, 3'd1, 6, 3, 3, 4, 5'd8, 0);
    drain();

    send_pkt(4'd1, 3'd7, 3, 5, 0, 2, 5'd30, 0);
    send_pkt(4'd2, 3'd4, 2, 2, 2, 1, 5'd11, 0);
    drain();

    send_pkt(4'd7, 3'd3, 0, 0, 0, 0, 5'd0, 0);
    send_pkt(4'd15, 3'd5, 4, 4, 4, 0, 5'd31, 2);
    drain();

    rdy_rand = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 9);
      if (mode < 7 || len == 1) begin n = len; e = len; end
      else if (mode < 9) begin e = $urandom_range(1, len - 1); n = e; end
      else begin e = 0; n = len + $urandom_range(0, 2); end
      send_pkt(4'($urandom), 3'($urandom), len, n, e, $urandom_range(0, 35), 5'($urandom), 0);
    end
    drain();

    rdy_rand = 1'b0;
    @(negedge clk);
    xfer_ready = 1'b0;
    send_pkt(4'd6, 3'd2, 10, 10, 10, 2, 5'd21, 0);
    repeat (8) @(negedge clk);
    chk("stalled_in_stream", 32'(xfer_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_fifo_empty", 32'(xfer_vld), 32'd0);
    send_pkt(4'd12, 3'd1, 5, 5, 5, 3, 5'd9, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic int urandom_sram();
    return int'($urandom_range(0, 31));
  endfunction

endmodule
